lcd9_frame_ctrl: RTL and testbench

//  Parametrised controller for Philips-type colour LCDs on a 9-bit SPI link (bit8 = D/C).

---
 rtl/lcd9_frame_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_lcd9_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd9_frame_ctrl.sv
// Frame controller for 9-bit SPI colour LCDs: reset, init table, window setup, then pixel streaming.
// Init runs once; later frames begin at the window setup until the next iRst.
module lcd9_frame_ctrl #(
  parameter int          CLK_DIV      = 4,
  parameter int          RST_CYCLES   = 1024,
  parameter int          DELAY_CYCLES = 256,
  parameter int          WIDTH        = 132,
  parameter int          HEIGHT       = 132,
  parameter logic [7:0]  COLMOD_VAL   = 8'h02
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic [7:0] iMadctl,
  input  logic [7:0] iContrast,
  input  logic [7:0] iPixData,
  input  logic       iPixValid,
  output logic       oPixReady,
  output logic       oBusy,
  output logic       oFrameDone,
  output logic       oLcdRst,
  output logic       oLcdCs,
  output logic       oLcdSck,
  output logic       oLcdMosi
);

  // state    | meaning
  // IDLE     | waiting for iStart
  // RST_LO   | LCD reset held low for RST_CYCLES
  // RST_WT   | LCD reset released, wait RST_CYCLES, then launch the first init word
  // INIT     | sending the init command table (steps 0..10)
  // DLY      | idle gap inside the init table
  // WIN      | sending window setup and RAMWR (steps 11..17)
  // PIX      | streaming pixel words
  // DONE     | one-cycle frame-done pulse
  typedef enum logic [2:0] {
    IDLE, RST_LO, RST_WT, INIT, DLY, WIN, PIX, DONE
  } state_t;

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int MAXC  = (RST_CYCLES > DELAY_CYCLES) ? RST_CYCLES : DELAY_CYCLES;
  localparam int TW    = $clog2(MAXC + 1);
  localparam int PW    = $clog2(2 * CLK_DIV) > 0 ? $clog2(2 * CLK_DIV) : 1;

  localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);
  localparam logic [TW-1:0] RST_LOAD  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LOAD  = TW'(DELAY_CYCLES - 1);
  localparam logic [PW-1:0] PH_MID    = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_END    = PW'(2 * CLK_DIV - 1);
  localparam logic [7:0]    COL_END   = 8'(WIDTH - 1);
  localparam logic [7:0]    ROW_END   = 8'(HEIGHT - 1);

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [4:0]    step, step_nx;
  logic [CW-1:0] pix_cnt, pix_nx;
  logic          init_done, init_nx;
  logic [7:0]    madctl_q, madctl_nx;
  logic [7:0]    contrast_q, contrast_nx;
  logic          lcd_rst_q, lcd_rst_nx;

  logic          ser_start;
  logic [8:0]    ser_word;
  logic          ser_ready;
  logic          ser_busy, ser_gap;
  logic [3:0]    ser_bit;
  logic [PW-1:0] ser_phase;
  logic [8:0]    ser_shift;
  logic          cs_q, sck_q, mosi_q;

  logic [8:0]    cmd_word;
  logic          cmd_delay;
  logic          pix_ready, busy, frame_done;

  // Ready in the last gap cycle so back-to-back words keep exactly CLK_DIV cycles of CS high.
  assign ser_ready = !ser_busy || (ser_gap && ser_phase == PH_MID);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      ser_busy  <= 1'b0;
      ser_gap   <= 1'b0;
      ser_bit   <= 4'd0;
      ser_phase <= '0;
      ser_shift <= 9'd0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else if (ser_start) begin
      ser_busy  <= 1'b1;
      ser_gap   <= 1'b0;
      ser_bit   <= 4'd8;
      ser_phase <= '0;
      ser_shift <= ser_word;
      cs_q      <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= ser_word[8];
    end else if (ser_busy) begin
      if (ser_gap) begin
        if (ser_phase == PH_MID) ser_busy <= 1'b0;
        else ser_phase <= ser_phase + 1'b1;
      end else begin
        if (ser_phase == PH_MID) sck_q <= 1'b1;
        if (ser_phase == PH_END) begin
          sck_q     <= 1'b0;
          ser_phase <= '0;
          if (ser_bit == 4'd0) begin
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            ser_gap <= 1'b1;
          end else begin
            ser_bit   <= ser_bit - 4'd1;
            mosi_q    <= ser_shift[7];
            ser_shift <= {ser_shift[7:0], 1'b0};
          end
        end else begin
          ser_phase <= ser_phase + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cmd_word  = 9'h000;
    cmd_delay = 1'b0;
    case (step)
      5'd0:    cmd_word  = 9'h011;
      5'd1:    cmd_delay = 1'b1;
      5'd2:    cmd_word  = 9'h020;
      5'd3:    cmd_word  = 9'h03A;
      5'd4:    cmd_word  = {1'b1, COLMOD_VAL};
      5'd5:    cmd_word  = 9'h036;
      5'd6:    cmd_word  = {1'b1, madctl_q};
      5'd7:    cmd_word  = 9'h025;
      5'd8:    cmd_word  = {1'b1, contrast_q};
      5'd9:    cmd_delay = 1'b1;
      5'd10:   cmd_word  = 9'h029;
      5'd11:   cmd_word  = 9'h02B;
      5'd12:   cmd_word  = 9'h100;
      5'd13:   cmd_word  = {1'b1, ROW_END};
      5'd14:   cmd_word  = 9'h02A;
      5'd15:   cmd_word  = 9'h100;
      5'd16:   cmd_word  = {1'b1, COL_END};
      5'd17:   cmd_word  = 9'h02C;
      default: cmd_word  = 9'h000;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      timer      <= '0;
      step       <= 5'd0;
      pix_cnt    <= '0;
      init_done  <= 1'b0;
      madctl_q   <= 8'd0;
      contrast_q <= 8'd0;
      lcd_rst_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      step       <= step_nx;
      pix_cnt    <= pix_nx;
      init_done  <= init_nx;
      madctl_q   <= madctl_nx;
      contrast_q <= contrast_nx;
      lcd_rst_q  <= lcd_rst_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    step_nx     = step;
    pix_nx      = pix_cnt;
    init_nx     = init_done;
    madctl_nx   = madctl_q;
    contrast_nx = contrast_q;
    lcd_rst_nx  = lcd_rst_q;
    ser_start   = 1'b0;
    ser_word    = cmd_word;
    pix_ready   = 1'b0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    case (state)
      IDLE, DONE: begin
        busy       = 1'b0;
        frame_done = (state == DONE);
        if (iStart) begin
          madctl_nx   = iMadctl;
          contrast_nx = iContrast;
          if (init_done) begin
            state_nx = WIN;
            step_nx  = 5'd11;
            pix_nx   = '0;
          end else begin
            state_nx   = RST_LO;
            step_nx    = 5'd0;
            lcd_rst_nx = 1'b0;
            timer_nx   = RST_LOAD;
          end
        end else if (state == DONE) begin
          state_nx = IDLE;
        end
      end
      RST_LO: begin
        if (timer == '0) begin
          lcd_rst_nx = 1'b1;
          timer_nx   = RST_LOAD;
          state_nx   = RST_WT;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      RST_WT: begin
        // Launch step 0 on terminal count so CS falls exactly RST_CYCLES after release.
        if (timer == '0) begin
          ser_start = 1'b1;
          step_nx   = 5'd1;
          state_nx  = INIT;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      INIT, WIN: begin
        if (ser_ready) begin
          if (cmd_delay) begin
            timer_nx = DLY_LOAD;
            state_nx = DLY;
          end else begin
            ser_start = 1'b1;
            step_nx   = step + 5'd1;
            if (step == 5'd10) begin
              state_nx = WIN;
              init_nx  = 1'b1;
              pix_nx   = '0;
            end else if (step == 5'd17) begin
              state_nx = PIX;
            end
          end
        end
      end
      DLY: begin
        if (timer == '0) begin
          step_nx  = step + 5'd1;
          state_nx = INIT;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      PIX: begin
        pix_ready = ser_ready && (pix_cnt < TOTAL_C);
        ser_word  = {1'b1, iPixData};
        if (pix_ready && iPixValid) begin
          ser_start = 1'b1;
          pix_nx    = pix_cnt + 1'b1;
        end else if (ser_ready && pix_cnt == TOTAL_C) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign oPixReady  = pix_ready;
  assign oBusy      = busy;
  assign oFrameDone = frame_done;
  assign oLcdRst    = lcd_rst_q;
  assign oLcdCs     = cs_q;
  assign oLcdSck    = sck_q;
  assign oLcdMosi   = mosi_q;

endmodule

// File: tb/tb_lcd9_frame_ctrl.sv
// Bench for lcd9_frame_ctrl: SPI word decoder feeding a scoreboard of expected words,
// plus timing checks on reset, CS gaps and the frame-done pulse.
module tb_lcd9_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] madctl = 8'hC8;
  logic [7:0] contrast = 8'h30;
  logic [7:0] pix_data = 8'h00;
  logic       pix_valid = 1'b0;
  logic       pix_ready, busy, frame_done, lcd_rst, lcd_cs, lcd_sck, lcd_mosi;

  always #5 clk = ~clk;

  lcd9_frame_ctrl #(
    .CLK_DIV(2), .RST_CYCLES(16), .DELAY_CYCLES(8),
    .WIDTH(4), .HEIGHT(2), .COLMOD_VAL(8'h02)
  ) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iMadctl(madctl), .iContrast(contrast),
    .iPixData(pix_data), .iPixValid(pix_valid), .oPixReady(pix_ready), .oBusy(busy),
    .oFrameDone(frame_done), .oLcdRst(lcd_rst), .oLcdCs(lcd_cs), .oLcdSck(lcd_sck),
    .oLcdMosi(lcd_mosi)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];
  int low_len[$];
  int gap_len[$];
  int words_seen = 0, done_cnt = 0, pr_viol = 0, busy_viol = 0, rst_low_cnt = 0;
  int first_word = -1;
  int src_mode = 0, src_idx = 0, src_n = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int lim);
    n_cmp++;
    if (act < lim) begin
      n_err++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, lim);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // SPI decoder and scoreboard check
  logic prev_sck = 1'b0, prev_cs = 1'b1;
  int bit_cnt = 0, low_run = 0, high_run = 0;
  logic [8:0] sh = 9'd0;
  always @(negedge clk) begin
    if (rst) begin
      bit_cnt = 0; prev_sck = 1'b0; prev_cs = 1'b1; low_run = 0; high_run = 0;
    end else begin
      if (!lcd_cs) begin
        if (prev_cs) begin gap_len.push_back(high_run); high_run = 0; end
        low_run++;
        if (pix_ready) pr_viol++;
        if (lcd_sck && !prev_sck) begin
          sh = {sh[7:0], lcd_mosi};
          bit_cnt++;
          if (bit_cnt == 9) begin
            bit_cnt = 0;
            words_seen++;
            if (words_seen == 1) first_word = int'(sh);
            if (exp_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL spi_word: got 0x%0h, expected no word", sh);
            end else begin
              chk("spi_word", int'(sh), int'(exp_q.pop_front()));
            end
          end
        end
      end else begin
        if (!prev_cs) begin low_len.push_back(low_run); low_run = 0; end
        high_run++;
        bit_cnt = 0;
      end
      if (frame_done) begin done_cnt++; if (busy) busy_viol++; end
      if (!lcd_rst) rst_low_cnt++;
      prev_sck = lcd_sck; prev_cs = lcd_cs;
    end
  end

  // Pixel source: random valid; the expected word is queued on each handshake
  always @(negedge clk) begin
    if (src_mode == 1 && src_idx < src_n) begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_data  = 8'(src_idx);
      if (pix_valid && pix_ready) begin
        exp_q.push_back({1'b1, pix_data});
        src_idx++;
      end
    end else if (src_mode == 2) begin
      pix_valid = 1'b1;
      pix_data  = 8'hAA;
    end else begin
      pix_valid = 1'b0;
    end
  end

  task automatic push_win();
    exp_q.push_back(9'h02B); exp_q.push_back(9'h100); exp_q.push_back(9'h101);
    exp_q.push_back(9'h02A); exp_q.push_back(9'h100); exp_q.push_back(9'h103);
    exp_q.push_back(9'h02C);
  endtask

  task automatic push_full();
    exp_q.push_back(9'h011); exp_q.push_back(9'h020); exp_q.push_back(9'h03A);
    exp_q.push_back(9'h102); exp_q.push_back(9'h036); exp_q.push_back(9'h1C8);
    exp_q.push_back(9'h025); exp_q.push_back(9'h130); exp_q.push_back(9'h029);
    push_win();
  endtask

  task automatic clear_logs();
    low_len.delete(); gap_len.delete();
    words_seen = 0; done_cnt = 0; pr_viol = 0; busy_viol = 0; rst_low_cnt = 0;
    first_word = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic start_src(input int n);
    src_idx = 0; src_n = n; src_mode = 1;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt < 1 && t < 6000) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
  endtask

  task automatic measure_reset(input string tag);
    int n = 0;
    int m = 0;
    while (lcd_rst == 1'b0 && n < 200) begin n++; @(negedge clk); end
    chk({tag, "_rst_low_cycles"}, n, 16);
    while (lcd_cs == 1'b1 && m < 200) begin m++; @(negedge clk); end
    chk({tag, "_rst_wait_cycles"}, m, 16);
  endtask

  task automatic check_full_frame(input string tag);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_at_done"}, busy_viol, 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
    chk({tag, "_words_left"}, exp_q.size(), 0);
    chk({tag, "_words_seen"}, words_seen, 24);
    chk({tag, "_pixels_taken"}, src_idx, 8);
    chk({tag, "_first_word_len"}, at(low_len, 0), 36);
    chk_ge({tag, "_gap_after_sleepout"}, at(gap_len, 1), 8);
    chk_ge({tag, "_gap_before_dispon"}, at(gap_len, 8), 8);
    chk({tag, "_cs_gap_b2b"}, at(gap_len, 3), 2);
    chk({tag, "_ready_during_word"}, pr_viol, 0);
  endtask

  initial begin
    int rdy;
    repeat (3) @(negedge clk);
    chk("reset_lcd_rst", int'(lcd_rst), 0);
    chk("reset_cs", int'(lcd_cs), 1);
    chk("reset_sck", int'(lcd_sck), 0);
    chk("reset_mosi", int'(lcd_mosi), 0);
    chk("reset_pix_ready", int'(pix_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    clear_logs();

    // valid held high in IDLE must not be consumed
    src_mode = 2;
    rdy = 0;
    repeat (20) begin @(negedge clk); if (pix_ready) rdy++; end
    chk("idle_ready_cycles", rdy, 0);
    chk("idle_words", words_seen, 0);
    chk("idle_busy", int'(busy), 0);
    src_mode = 0;
    @(negedge clk);

    // frame 1: full reset, init, window, 8 pixels; stray starts while busy
    clear_logs();
    push_full();
    start_src(8);
    pulse_start();
    measure_reset("f1");
    repeat (50) @(negedge clk);
    pulse_start();
    repeat (300) @(negedge clk);
    pulse_start();
    wait_done();
    check_full_frame("f1");
    src_mode = 0;

    // frame 2: init skipped
    clear_logs();
    push_win();
    start_src(8);
    pulse_start();
    wait_done();
    chk("f2_done_pulses", done_cnt, 1);
    chk("f2_rst_low_cycles", rst_low_cnt, 0);
    chk("f2_first_word", first_word, 9'h02B);
    chk("f2_words_seen", words_seen, 15);
    chk("f2_words_left", exp_q.size(), 0);
    chk("f2_pixels_taken", src_idx, 8);
    src_mode = 0;

    // frame 3: reset in the middle of pixel 3
    clear_logs();
    push_win();
    start_src(8);
    pulse_start();
    begin
      int t = 0;
      while (src_idx < 4 && t < 3000) begin @(negedge clk); t++; end
      chk("f3_reached_pixel3", src_idx, 4);
    end
    repeat (6) @(negedge clk);
    chk("f3_midword_cs", int'(lcd_cs), 0);
    src_mode = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("f3_rst_cs", int'(lcd_cs), 1);
    chk("f3_rst_sck", int'(lcd_sck), 0);
    chk("f3_rst_lcd_rst", int'(lcd_rst), 0);
    chk("f3_rst_pix_ready", int'(pix_ready), 0);
    chk("f3_rst_busy", int'(busy), 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);

    // frame 4: full sequence must repeat after the reset
    clear_logs();
    push_full();
    start_src(8);
    pulse_start();
    measure_reset("f4");
    wait_done();
    check_full_frame("f4");
    src_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule
